execute_stage: RTL and testbench

- Execute stage of the 5-stage CPU; sits directly downstream of the D/X pipeline register and consumes its buffered outputs.
- Computes the ALU result, resolves branches and runs an iterative multi-cycle multiplier.
- Contains the X/M pipeline register: all data and control outputs are registered and feed the memory stage.
- Raises stall upstream while a multiply is in progress and flush upstream on a taken branch.

---
 rtl/execute_stage.sv | 161 ++++++++++++++++
 tb/tb_execute_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: ALU, BEQ resolution, iterative shift-add multiplier and the X/M pipeline register.
// Define EXEC_OVERFLOW_TRAP_EN to add the registered signed-overflow trap on ADD/SUB.
module execute_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_value,
  input  logic [DATA_WIDTH-1:0] read_data_0,
  input  logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [31:0]           immediate,
  input  logic [2:0]            alu_op,
  input  logic                  alu_src,
  input  logic                  branch,
  input  logic [3:0]            ctrl_in,
  input  logic                  reg_dst,
  input  logic [4:0]            rt_addr,
  input  logic [4:0]            rd_addr,
  output logic                  stall,
  output logic                  flush,
  output logic [31:0]           branch_target,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] store_data,
  output logic [4:0]            write_addr,
  output logic [3:0]            ctrl_out
`ifdef EXEC_OVERFLOW_TRAP_EN
  ,
  output logic                  overflow
`endif
);

  localparam int MUL_CYCLES = DATA_WIDTH / MUL_STEP_BITS;
  localparam int CW         = $clog2(MUL_CYCLES + 1);
  localparam int MSB        = DATA_WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_NOP = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]         cnt;

  logic [DATA_WIDTH-1:0] op_b, sum, diff, res;
  logic [3:0]            ctrl_nxt;
  logic [4:0]            waddr_nxt;
  logic                  taken, accept, mul_start;
`ifdef EXEC_OVERFLOW_TRAP_EN
  logic                  ovf;
`endif

  assign op_b      = alu_src ? immediate[DATA_WIDTH-1:0] : read_data_1;
  assign taken     = (read_data_0 == read_data_1);
  assign waddr_nxt = reg_dst ? rd_addr : rt_addr;

  // The cycle after a taken branch, X holds a wrong-path instruction: squash it here.
  assign accept    = (state == IDLE) && !flush;
  assign mul_start = accept && (alu_op == OP_MUL) && !branch;
  assign stall     = rst && (mul_start || (state == BUSY));

  always_comb begin
    sum      = read_data_0 + op_b;
    diff     = read_data_0 - op_b;
    res      = '0;
    ctrl_nxt = ctrl_in;
    if (branch) begin
      res = diff;
      if (taken) ctrl_nxt = '0;
    end else begin
      case (alu_op)
        OP_ADD:  res = sum;
        OP_NOP:  ctrl_nxt = '0;
        OP_SUB:  res = diff;
        OP_AND:  res = read_data_0 & op_b;
        OP_OR:   res = read_data_0 | op_b;
        OP_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, ($signed(read_data_0) < $signed(op_b))};
        OP_XOR:  res = read_data_0 ^ op_b;
        default: res = '0;
      endcase
    end
`ifdef EXEC_OVERFLOW_TRAP_EN
    ovf = !branch &&
          (((alu_op == OP_ADD) && (read_data_0[MSB] == op_b[MSB]) && (sum[MSB]  != read_data_0[MSB])) ||
           ((alu_op == OP_SUB) && (read_data_0[MSB] != op_b[MSB]) && (diff[MSB] != read_data_0[MSB])));
    // Trapped result still flows to M, but must not reach the register file.
    if (ovf) ctrl_nxt[1] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      flush         <= 1'b0;
      branch_target <= '0;
      alu_result    <= '0;
      store_data    <= '0;
      write_addr    <= '0;
      ctrl_out      <= '0;
`ifdef EXEC_OVERFLOW_TRAP_EN
      overflow      <= 1'b0;
`endif
    end else begin
      // Bubble unless a state below issues a real instruction; data fields hold.
      flush    <= 1'b0;
      ctrl_out <= '0;
`ifdef EXEC_OVERFLOW_TRAP_EN
      overflow <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mul_start) begin
            state  <= BUSY;
            mcand  <= read_data_0;
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
          end else if (accept) begin
            flush         <= branch && taken;
            branch_target <= pc_value + (immediate << 2);
            alu_result    <= res;
            store_data    <= read_data_1;
            write_addr    <= waddr_nxt;
            ctrl_out      <= ctrl_nxt;
`ifdef EXEC_OVERFLOW_TRAP_EN
            overflow      <= ovf;
`endif
          end
        end
        BUSY: begin
          acc    <= acc + mcand * DATA_WIDTH'(mplier[MUL_STEP_BITS-1:0]);
          mcand  <= mcand << MUL_STEP_BITS;
          mplier <= mplier >> MUL_STEP_BITS;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(MUL_CYCLES - 1)) state <= DONE;
        end
        DONE: begin
          // Upstream held D/X through the stall, so ctrl_in/addresses still belong to the MUL.
          alu_result <= acc;
          store_data <= read_data_1;
          write_addr <= waddr_nxt;
          ctrl_out   <= ctrl_in;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected X/M contents queued at drive time, popped at output.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_value, read_data_0, read_data_1, immediate;
  logic [2:0]  alu_op;
  logic        alu_src, branch, reg_dst;
  logic [3:0]  ctrl_in;
  logic [4:0]  rt_addr, rd_addr;
  logic        stall, flush;
  logic [31:0] branch_target, alu_result, store_data;
  logic [4:0]  write_addr;
  logic [3:0]  ctrl_out;
`ifdef EXEC_OVERFLOW_TRAP_EN
  logic        overflow;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  ctrl;
    logic [4:0]  waddr;
    logic        fl;
    logic [31:0] store;
  } obs_t;

  obs_t got;
  obs_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  assign got = {alu_result, ctrl_out, write_addr, flush, store_data};

  always #5 clk = ~clk;

  execute_stage #(.DATA_WIDTH(32), .MUL_STEP_BITS(1)) dut (
    .clk(clk), .rst(rst), .pc_value(pc_value), .read_data_0(read_data_0),
    .read_data_1(read_data_1), .immediate(immediate), .alu_op(alu_op), .alu_src(alu_src),
    .branch(branch), .ctrl_in(ctrl_in), .reg_dst(reg_dst), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .stall(stall), .flush(flush), .branch_target(branch_target), .alu_result(alu_result),
    .store_data(store_data), .write_addr(write_addr), .ctrl_out(ctrl_out)
`ifdef EXEC_OVERFLOW_TRAP_EN
    , .overflow(overflow)
`endif
  );

  function automatic obs_t model(input logic [2:0] op, input logic [31:0] a, b, imm,
                                 input logic src, br, input logic [3:0] ctrl,
                                 input logic rdst, input logic [4:0] rt, rd);
    logic [31:0] ob;
    longint      wide;
    obs_t        r;
    ob      = src ? imm : b;
    r.waddr = rdst ? rd : rt;
    r.store = b;
    r.fl    = 1'b0;
    r.ctrl  = ctrl;
    r.res   = 32'h0;
    if (br) begin
      r.res = a - ob;
      if (a == b) begin r.fl = 1'b1; r.ctrl = 4'h0; end
    end else begin
      case (op)
        3'd0: r.res = a + ob;
        3'd1: r.ctrl = 4'h0;
        3'd2: r.res = a - ob;
        3'd3: r.res = a & ob;
        3'd4: r.res = a | ob;
        3'd5: r.res = ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
        3'd6: r.res = a ^ ob;
        default: r.res = a * ob;
      endcase
    end
`ifdef EXEC_OVERFLOW_TRAP_EN
    wide = (op == 3'd0) ? longint'($signed(a)) + longint'($signed(ob))
                        : longint'($signed(a)) - longint'($signed(ob));
    if (!br && (op == 3'd0 || op == 3'd2) && (wide > 64'sd2147483647 || wide < -64'sd2147483648))
      r.ctrl[1] = 1'b0;
`else
    wide = 0;
`endif
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, b, imm, input logic src, br,
                       input logic [3:0] ctrl, input logic rdst, input logic [4:0] rt, rd,
                       input logic [31:0] pc, input bit push);
    alu_op = op; read_data_0 = a; read_data_1 = b; immediate = imm; alu_src = src;
    branch = br; ctrl_in = ctrl; reg_dst = rdst; rt_addr = rt; rd_addr = rd; pc_value = pc;
    if (push) exp_q.push_back(model(op, a, b, imm, src, br, ctrl, rdst, rt, rd));
  endtask

  task automatic bubble;
    drive(3'd1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic test_reset;
    obs_t e;
    bubble;
    #3 rst = 1'b0;
    tick; tick;
    checks++;
    if ({got, branch_target, stall} !== '0)
      $display("FAIL reset_init: got %h/%h/%b want 0", got, branch_target, stall);
    else passes++;
    rst = 1'b1;
    drive(3'd0, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 4'b1010, 1'b0, 5'd4, 5'd7, 32'h40, 1'b1);
    tick;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL reset_pre_add: got %h want %h", got, e); else passes++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({got, branch_target, stall} !== '0)
      $display("FAIL reset_async: got %h/%h/%b want 0", got, branch_target, stall);
    else passes++;
    drive(3'd0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 4'b0010, 1'b1, 5'd8, 5'd3, 32'h0, 1'b1);
    #1 rst = 1'b1;
    tick;
    e = exp_q.pop_front();
    checks++;
    if (got !== e || alu_result !== 32'd12 || write_addr !== 5'd3)
      $display("FAIL reset_add_5_7: got %h want %h", got, e);
    else passes++;
  endtask

  task automatic test_imm_slt;
    obs_t e;
    drive(3'd5, 32'hFFFF_FFFF, 32'h55, 32'h1, 1'b1, 1'b0, 4'b0010, 1'b0, 5'd2, 5'd0, 32'h0, 1'b1);
    tick;
    e = exp_q.pop_front();
    checks++;
    if (got !== e || alu_result !== 32'd1) $display("FAIL slt_imm: got %h want %h", got, e); else passes++;
    drive(3'd0, 32'hFFFF_FFFF, 32'h55, 32'h1, 1'b1, 1'b0, 4'b0010, 1'b0, 5'd2, 5'd0, 32'h0, 1'b1);
    tick;
    e = exp_q.pop_front();
    checks++;
    if (got !== e || alu_result !== 32'd0) $display("FAIL add_imm_wrap: got %h want %h", got, e); else passes++;
  endtask

  task automatic test_alu;
    obs_t e;
    drive(3'd2, 32'd0, 32'd1, 32'h0, 1'b0, 1'b0, 4'b0010, 1'b1, 5'd1, 5'd31, 32'h0, 1'b1);
    tick;
    e = exp_q.pop_front();
    checks++;
    if (got !== e || alu_result !== 32'hFFFF_FFFF) $display("FAIL sub_wrap: got %h want %h", got, e); else passes++;
    for (int i = 0; i < 12; i++) begin
      drive(3'($urandom_range(0, 6)), $urandom, $urandom, $urandom, 1'($urandom), 1'b0,
            4'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b1);
      tick;
      e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL alu_rand[%0d] op=%0d: got %h want %h", i, alu_op, got, e); else passes++;
    end
  endtask

  task automatic test_branch;
    obs_t e;
    drive(3'd4, 32'h10, 32'h10, 32'h4, 1'b0, 1'b1, 4'h0, 1'b0, 5'd0, 5'd0, 32'h100, 1'b1);
    tick;
    e = exp_q.pop_front();
    checks++;
    if (got !== e || flush !== 1'b1) $display("FAIL br_taken: got %h want %h", got, e); else passes++;
    checks++;
    if (branch_target !== 32'h110) $display("FAIL br_target: got %h want 00000110", branch_target);
    else passes++;
    bubble;
    tick;
    checks++;
    if (flush !== 1'b0 || ctrl_out !== 4'h0)
      $display("FAIL br_flush_pulse: got flush=%b ctrl=%h want 0/0", flush, ctrl_out);
    else passes++;
    drive(3'd0, 32'h10, 32'h20, 32'h4, 1'b0, 1'b1, 4'h0, 1'b0, 5'd0, 5'd0, 32'h200, 1'b1);
    tick;
    e = exp_q.pop_front();
    checks++;
    if (got !== e || flush !== 1'b0) $display("FAIL br_not_taken: got %h want %h", got, e); else passes++;
  endtask

  task automatic test_mul(input logic [31:0] a, b, input string name);
    obs_t        e;
    int          n, bad;
    logic [31:0] held;
    held = alu_result;
    drive(3'd7, a, b, 32'h0, 1'b0, 1'b0, 4'b0010, 1'b1, 5'd1, 5'd9, 32'h0, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b1) $display("FAIL %s_stall_start: got %b want 1", name, stall); else passes++;
    n = 0; bad = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      tick;
      if (stall === 1'b1 && (ctrl_out !== 4'h0 || flush !== 1'b0 || alu_result !== held)) bad++;
    end
    checks++;
    if (n != 33) $display("FAIL %s_stall_len: got %0d want 33", name, n); else passes++;
    checks++;
    if (bad != 0) $display("FAIL %s_bubble: got %0d bad cycles want 0", name, bad); else passes++;
    tick;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL %s_result: got %h want %h", name, got, e); else passes++;
  endtask

  task automatic test_back_to_back;
    test_mul(32'd6, 32'd7, "mul_6x7");
    test_mul(32'hFFFF_FFFF, 32'd2, "mul_neg1x2");
    bubble;
    tick;
  endtask

  task automatic test_reset_mid_mul;
    drive(3'd7, 32'd123, 32'd456, 32'h0, 1'b0, 1'b0, 4'b0010, 1'b1, 5'd1, 5'd9, 32'h0, 1'b0);
    tick;
    repeat (10) tick;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({got, branch_target, stall} !== '0)
      $display("FAIL mid_mul_reset: got %h/%h/%b want 0", got, branch_target, stall);
    else passes++;
    bubble;
    #1 rst = 1'b1;
    tick;
    test_mul(32'd3, 32'd3, "mul_3x3");
    bubble;
    tick;
  endtask

`ifdef EXEC_OVERFLOW_TRAP_EN
  task automatic test_overflow;
    obs_t e;
    drive(3'd0, 32'h7FFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0, 4'b0010, 1'b0, 5'd5, 5'd0, 32'h0, 1'b1);
    tick;
    e = exp_q.pop_front();
    checks++;
    if (got !== e || alu_result !== 32'h8000_0000 || ctrl_out[1] !== 1'b0)
      $display("FAIL ovf_add: got %h want %h", got, e);
    else passes++;
    checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else passes++;
    bubble;
    tick;
    checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else passes++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_imm_slt;
    test_alu;
    test_branch;
    test_back_to_back;
    test_reset_mid_mul;
`ifdef EXEC_OVERFLOW_TRAP_EN
    test_overflow;
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
